eval_scheduler: RTL and testbench

EVAL_SCHEDULER -- requirements
Module: eval_scheduler

---
 rtl/eval_scheduler.sv | 109 ++++++++++
 tb/tb_eval_scheduler.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/eval_scheduler.sv
// Round-robin scheduler that applies one requester's 2-bit vector to an external
// combinational circuit, waits SETTLE_CYCLES edges, samples its LED and returns it.
module eval_scheduler #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_req0_valid,
    input  logic             in_req1_valid,
    input  logic [1:0]       in_req0_vec,
    input  logic [1:0]       in_req1_vec,
    output logic             out_req0_ready,
    output logic             out_req1_ready,
    output logic             out_rsp_valid,
    output logic             out_rsp_id,
    output logic [1:0]       out_rsp_vec,
    output logic             out_rsp_led,
    input  logic             in_rsp_ready,
    output logic             out_inputNodeSwitch1,
    output logic             out_inputNodeSwitch2,
    input  logic             in_outputNodeLed,
    output logic             out_busy,
    output logic [CNT_W-1:0] out_eval_count
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RESP} state_t;

    state_t           r_state;
    logic             r_ptr;
    logic [7:0]       r_settle;
    logic [1:0]       r_sw;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [1:0]       r_rsp_vec;
    logic             r_rsp_led;
    logic             r_busy;
    logic [CNT_W-1:0] r_eval_cnt;

    logic       w_idle;
    logic       w_gnt1;
    logic       w_acc;
    logic [1:0] w_vec;

    // Readies are combinational, so they are gated by reset to stay low while it is held.
    assign w_idle = (r_state == S_IDLE) && !in_rst;
    assign w_gnt1 = in_req1_valid && (!in_req0_valid || r_ptr);
    assign w_acc  = w_idle && (in_req0_valid || in_req1_valid);
    assign w_vec  = w_gnt1 ? in_req1_vec : in_req0_vec;

    assign out_req0_ready       = w_idle && in_req0_valid && !w_gnt1;
    assign out_req1_ready       = w_idle && w_gnt1;
    assign out_rsp_valid        = r_rsp_valid;
    assign out_rsp_id           = r_rsp_id;
    assign out_rsp_vec          = r_rsp_vec;
    assign out_rsp_led          = r_rsp_led;
    assign out_inputNodeSwitch1 = r_sw[0];
    assign out_inputNodeSwitch2 = r_sw[1];
    assign out_busy             = r_busy;
    assign out_eval_count       = r_eval_cnt;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= 1'b0;
            r_settle    <= '0;
            r_sw        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_vec   <= '0;
            r_rsp_led   <= 1'b0;
            r_busy      <= 1'b0;
            r_eval_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_state   <= S_SETTLE;
                        r_rsp_id  <= w_gnt1;
                        r_rsp_vec <= w_vec;
                        r_sw      <= w_vec;
                        r_settle  <= 8'(SETTLE_CYCLES);
                        r_ptr     <= !w_gnt1;
                        r_busy    <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    r_settle <= r_settle - 8'd1;
                    if (r_settle == 8'd1) begin
                        r_state     <= S_RESP;
                        r_rsp_led   <= in_outputNodeLed;
                        r_rsp_valid <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (in_rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        if (r_eval_cnt != {CNT_W{1'b1}})
                            r_eval_cnt <= r_eval_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eval_scheduler.sv
// Directed bench for eval_scheduler; a second instance with CNT_W=2 shares the
// stimulus to exercise counter saturation.
module tb_eval_scheduler;

    logic       in_clk = 1'b0;
    logic       in_rst;
    logic       in_req0_valid, in_req1_valid;
    logic [1:0] in_req0_vec, in_req1_vec;
    logic       in_rsp_ready;
    logic       out_req0_ready, out_req1_ready;
    logic       out_rsp_valid, out_rsp_id, out_rsp_led;
    logic [1:0] out_rsp_vec;
    logic       out_inputNodeSwitch1, out_inputNodeSwitch2;
    logic       in_outputNodeLed;
    logic       out_busy;
    logic [7:0] out_eval_count;

    logic       b_req0_ready, b_req1_ready, b_rsp_valid, b_rsp_id, b_rsp_led;
    logic [1:0] b_rsp_vec;
    logic       b_sw1, b_sw2, b_led, b_busy;
    logic [1:0] b_eval_count;

    int n_chk = 0;
    int n_fail = 0;

    always #5 in_clk = ~in_clk;

    // Generated circuit: LED = s1 | (s1 & s2)
    assign in_outputNodeLed = out_inputNodeSwitch1 | (out_inputNodeSwitch1 & out_inputNodeSwitch2);
    assign b_led            = b_sw1 | (b_sw1 & b_sw2);

    eval_scheduler #(.SETTLE_CYCLES(2), .CNT_W(8)) dut (
        .in_clk(in_clk), .in_rst(in_rst),
        .in_req0_valid(in_req0_valid), .in_req1_valid(in_req1_valid),
        .in_req0_vec(in_req0_vec), .in_req1_vec(in_req1_vec),
        .out_req0_ready(out_req0_ready), .out_req1_ready(out_req1_ready),
        .out_rsp_valid(out_rsp_valid), .out_rsp_id(out_rsp_id),
        .out_rsp_vec(out_rsp_vec), .out_rsp_led(out_rsp_led),
        .in_rsp_ready(in_rsp_ready),
        .out_inputNodeSwitch1(out_inputNodeSwitch1), .out_inputNodeSwitch2(out_inputNodeSwitch2),
        .in_outputNodeLed(in_outputNodeLed),
        .out_busy(out_busy), .out_eval_count(out_eval_count)
    );

    eval_scheduler #(.SETTLE_CYCLES(2), .CNT_W(2)) dut_sat (
        .in_clk(in_clk), .in_rst(in_rst),
        .in_req0_valid(in_req0_valid), .in_req1_valid(in_req1_valid),
        .in_req0_vec(in_req0_vec), .in_req1_vec(in_req1_vec),
        .out_req0_ready(b_req0_ready), .out_req1_ready(b_req1_ready),
        .out_rsp_valid(b_rsp_valid), .out_rsp_id(b_rsp_id),
        .out_rsp_vec(b_rsp_vec), .out_rsp_led(b_rsp_led),
        .in_rsp_ready(in_rsp_ready),
        .out_inputNodeSwitch1(b_sw1), .out_inputNodeSwitch2(b_sw2),
        .in_outputNodeLed(b_led),
        .out_busy(b_busy), .out_eval_count(b_eval_count)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!out_rsp_valid && lat < 30) begin
            @(negedge in_clk);
            lat++;
        end
        chk("rsp_arrives", out_rsp_valid, 1);
    endtask

    // Checks the response fields, then lets the handshake edge pass (in_rsp_ready assumed high).
    task automatic check_rsp(input string tag, input logic id, input logic [1:0] vec, input logic led,
                             input int cnt, input int cnt_sat);
        int lat;
        wait_rsp(lat);
        chk({tag, "_id"}, out_rsp_id, id);
        chk({tag, "_vec"}, out_rsp_vec, vec);
        chk({tag, "_led"}, out_rsp_led, led);
        @(negedge in_clk);
        chk({tag, "_vld_clr"}, out_rsp_valid, 0);
        chk({tag, "_cnt"}, out_eval_count, cnt);
        chk({tag, "_cnt_sat"}, b_eval_count, cnt_sat);
    endtask

    initial begin
        int lat;
        in_rst = 1'b1;
        in_req0_valid = 1'b0; in_req1_valid = 1'b0;
        in_req0_vec = 2'b00;  in_req1_vec = 2'b00;
        in_rsp_ready = 1'b0;

        // Reset state, with a request present that must not see ready
        repeat (2) @(negedge in_clk);
        in_req0_valid = 1'b1;
        #1;
        chk("rst_ready0", out_req0_ready, 0);
        chk("rst_busy", out_busy, 0);
        chk("rst_rsp_valid", out_rsp_valid, 0);
        chk("rst_sw", {out_inputNodeSwitch2, out_inputNodeSwitch1}, 2'b00);
        chk("rst_cnt", out_eval_count, 0);
        in_req0_valid = 1'b0;

        // Single request from req0, grant in the first cycle after reset
        @(negedge in_clk);
        in_rst = 1'b0;
        in_req0_valid = 1'b1; in_req0_vec = 2'b01; in_rsp_ready = 1'b1;
        #1;
        chk("single_ready0", out_req0_ready, 1);
        chk("single_ready1", out_req1_ready, 0);
        @(negedge in_clk);
        in_req0_valid = 1'b0;
        chk("single_busy", out_busy, 1);
        chk("single_sw", {out_inputNodeSwitch2, out_inputNodeSwitch1}, 2'b01);
        chk("single_settle_vld", out_rsp_valid, 0);
        wait_rsp(lat);
        chk("single_latency", lat, 2);
        chk("single_id", out_rsp_id, 0);
        chk("single_vec", out_rsp_vec, 2'b01);
        chk("single_led", out_rsp_led, 1);
        @(negedge in_clk);
        chk("single_done_busy", out_busy, 0);
        chk("single_cnt", out_eval_count, 1);
        chk("single_cnt_sat", b_eval_count, 1);

        // Single request from req1 so the pointer then favours req0
        in_req1_valid = 1'b1; in_req1_vec = 2'b11;
        #1;
        chk("req1_ready1", out_req1_ready, 1);
        chk("req1_ready0", out_req0_ready, 0);
        @(negedge in_clk);
        in_req1_valid = 1'b0;
        check_rsp("req1", 1'b1, 2'b11, 1'b1, 2, 2);

        // Contention: grants alternate 0,1,0,1
        in_req0_valid = 1'b1; in_req0_vec = 2'b10;
        in_req1_valid = 1'b1; in_req1_vec = 2'b11;
        for (int k = 0; k < 4; k++) begin
            logic id;
            id = 1'(k % 2);
            check_rsp($sformatf("cont%0d", k), id, id ? 2'b11 : 2'b10, id, 3 + k, 3);
        end
        in_req0_valid = 1'b0; in_req1_valid = 1'b0;

        // Backpressure: hold RESP for 5 cycles while req1 keeps asking
        in_rsp_ready = 1'b0;
        in_req0_valid = 1'b1; in_req0_vec = 2'b01;
        in_req1_valid = 1'b1; in_req1_vec = 2'b10;
        #1;
        chk("bp_ready0", out_req0_ready, 1);
        @(negedge in_clk);
        in_req0_valid = 1'b0;
        wait_rsp(lat);
        for (int k = 0; k < 5; k++) begin
            @(negedge in_clk);
            chk("bp_hold_vld", out_rsp_valid, 1);
            chk("bp_hold_fields", {out_rsp_id, out_rsp_vec, out_rsp_led}, {1'b0, 2'b01, 1'b1});
            chk("bp_hold_ready1", out_req1_ready, 0);
            chk("bp_hold_busy", out_busy, 1);
        end
        in_rsp_ready = 1'b1;
        @(negedge in_clk);
        chk("bp_hs_vld", out_rsp_valid, 0);
        chk("bp_hs_cnt", out_eval_count, 7);
        chk("bp_hs_ready1", out_req1_ready, 1);
        chk("bp_hs_sw_hold", {out_inputNodeSwitch2, out_inputNodeSwitch1}, 2'b01);
        @(negedge in_clk);
        in_req1_valid = 1'b0;
        chk("bp_next_sw", {out_inputNodeSwitch2, out_inputNodeSwitch1}, 2'b10);
        check_rsp("bp_next", 1'b1, 2'b10, 1'b0, 8, 3);

        // Reset in the middle of SETTLE aborts the evaluation
        in_req0_valid = 1'b1; in_req0_vec = 2'b11;
        @(negedge in_clk);
        in_req0_valid = 1'b0;
        chk("abort_busy_pre", out_busy, 1);
        in_rst = 1'b1;
        #1;
        chk("abort_busy", out_busy, 0);
        chk("abort_sw", {out_inputNodeSwitch2, out_inputNodeSwitch1}, 2'b00);
        chk("abort_rsp_valid", out_rsp_valid, 0);
        chk("abort_cnt", out_eval_count, 0);
        @(negedge in_clk);
        in_rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge in_clk);
            chk("abort_no_rsp", out_rsp_valid, 0);
        end
        in_req1_valid = 1'b1; in_req1_vec = 2'b01;
        #1;
        chk("post_rst_ready1", out_req1_ready, 1);
        @(negedge in_clk);
        in_req1_valid = 1'b0;
        check_rsp("post_rst", 1'b1, 2'b01, 1'b1, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
